game_flow_ctrl: RTL and testbench

- Top-level game sequencer for the breakout design, on the VGA clock domain.
- Debounces the start and pause keys and drives `game_state` and the one-cycle `game_reset` pulse consumed by the ball/racket and brick blocks.
- Tracks lives, score and remaining bricks from `lose_sig` and the 50-bit `brick_collision` vector.
- Decides respawn, win and game-over.

---
 rtl/game_flow_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Breakout game sequencer: debounced start/pause keys, the serve/play/pause/win/over
// state machine, and the lives, score and remaining-brick bookkeeping.

module key_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync;
    logic          sample;
    logic          level;
    logic [CW-1:0] cnt;

    // Raw key is active-low; everything after the synchronizer is active-high.
    assign sample = ~sync[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key};
            press <= 1'b0;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sample;
                cnt   <= '0;
                press <= sample;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module game_flow_ctrl #(
    parameter int NUM_BRICKS       = 50,
    parameter int INIT_LIVES       = 3,
    parameter int POINTS_PER_BRICK = 10,
    parameter int DEBOUNCE_CYC     = 250000,
    parameter int SERVE_CYC        = 25000000
) (
    input  logic                  vga_clk,
    input  logic                  sys_rst_n,
    input  logic                  start_key,
    input  logic                  pause_key,
    input  logic                  lose_sig,
    input  logic [NUM_BRICKS-1:0] brick_collision,
    output logic [1:0]            game_state,
    output logic                  game_reset,
    output logic [2:0]            lives,
    output logic [15:0]           score,
    output logic [5:0]            bricks_left,
    output logic                  serve_active
);
    localparam int SCW = (SERVE_CYC > 1) ? $clog2(SERVE_CYC + 1) : 1;
    localparam logic [SCW-1:0] SERVE_MAX   = SCW'(SERVE_CYC - 1);
    localparam logic [2:0]     LIVES_INIT  = 3'(INIT_LIVES);
    localparam logic [5:0]     BRICKS_INIT = 6'(NUM_BRICKS);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        PAUSE,
        WIN,
        OVER
    } state_t;

    state_t                state, state_nxt;
    logic [SCW-1:0]        serve_cnt, serve_cnt_nxt;
    logic [2:0]            lives_nxt;
    logic [15:0]           score_nxt;
    logic [5:0]            bricks_nxt;
    logic                  game_reset_nxt;
    logic [NUM_BRICKS-1:0] prev_collision;
    logic [NUM_BRICKS-1:0] new_hits;
    logic                  lose_prev;
    logic                  lose_edge;
    logic                  start_press;
    logic                  pause_press;
    logic [5:0]            hit_cnt;
    logic [16:0]           score_sum;
    logic                  win_now;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_db (
        .clk   (vga_clk),
        .rst_n (sys_rst_n),
        .key   (start_key),
        .press (start_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pause_db (
        .clk   (vga_clk),
        .rst_n (sys_rst_n),
        .key   (pause_key),
        .press (pause_press)
    );

    // NOTE: every always_comb output gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        new_hits = brick_collision & ~prev_collision;
        hit_cnt  = '0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            hit_cnt = hit_cnt + 6'(new_hits[i]);
        end
    end

    assign lose_edge = lose_sig & ~lose_prev;
    assign score_sum = {1'b0, score} + 17'(hit_cnt) * 17'(POINTS_PER_BRICK);
    assign win_now   = (hit_cnt >= bricks_left);

    always_comb begin
        state_nxt      = state;
        serve_cnt_nxt  = serve_cnt;
        lives_nxt      = lives;
        score_nxt      = score;
        bricks_nxt     = bricks_left;
        game_reset_nxt = 1'b0;

        case (state)
            IDLE, WIN, OVER: begin
                if (start_press) begin
                    state_nxt      = SERVE;
                    serve_cnt_nxt  = '0;
                    lives_nxt      = LIVES_INIT;
                    score_nxt      = '0;
                    bricks_nxt     = BRICKS_INIT;
                    game_reset_nxt = 1'b1;
                end
            end

            SERVE: begin
                if (serve_cnt == SERVE_MAX) begin
                    state_nxt     = PLAY;
                    serve_cnt_nxt = '0;
                end else begin
                    serve_cnt_nxt = serve_cnt + SCW'(1);
                end
            end

            PLAY: begin
                score_nxt  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                bricks_nxt = win_now ? 6'd0 : bricks_left - hit_cnt;
                // A win outranks a lose in the same cycle; pause yields to both.
                if (win_now) begin
                    state_nxt = WIN;
                end else if (lose_edge) begin
                    if (lives <= 3'd1) begin
                        lives_nxt = 3'd0;
                        state_nxt = OVER;
                    end else begin
                        lives_nxt      = lives - 3'd1;
                        state_nxt      = SERVE;
                        serve_cnt_nxt  = '0;
                        game_reset_nxt = 1'b1;
                    end
                end else if (pause_press) begin
                    state_nxt = PAUSE;
                end
            end

            PAUSE: begin
                if (pause_press) begin
                    state_nxt = PLAY;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Edge-detect history is tracked in every state so a pending lose or a held
    // brick flag is never counted twice across a pause or serve.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            serve_cnt      <= '0;
            lives          <= LIVES_INIT;
            score          <= '0;
            bricks_left    <= BRICKS_INIT;
            game_reset     <= 1'b0;
            prev_collision <= '0;
            lose_prev      <= 1'b0;
        end else begin
            state          <= state_nxt;
            serve_cnt      <= serve_cnt_nxt;
            lives          <= lives_nxt;
            score          <= score_nxt;
            bricks_left    <= bricks_nxt;
            game_reset     <= game_reset_nxt;
            prev_collision <= brick_collision;
            lose_prev      <= lose_sig;
        end
    end

    always_comb begin
        case (state)
            PLAY:    game_state = 2'b01;
            WIN:     game_state = 2'b10;
            OVER:    game_state = 2'b11;
            default: game_state = 2'b00;
        endcase
    end

    assign serve_active = (state == SERVE);
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short debounce/serve timing; all
// expected values are hand-computed constants.

module tb_game_flow_ctrl;
    localparam int NB = 50;

    logic          clk;
    logic          rst_n;
    logic          start_key;
    logic          pause_key;
    logic          lose_sig;
    logic [NB-1:0] brick_collision;
    logic [1:0]    game_state;
    logic          game_reset;
    logic [2:0]    lives;
    logic [15:0]   score;
    logic [5:0]    bricks_left;
    logic          serve_active;

    int n_cmp = 0;
    int n_err = 0;

    game_flow_ctrl #(
        .NUM_BRICKS       (NB),
        .INIT_LIVES       (3),
        .POINTS_PER_BRICK (10),
        .DEBOUNCE_CYC     (4),
        .SERVE_CYC        (8)
    ) dut (
        .vga_clk         (clk),
        .sys_rst_n       (rst_n),
        .start_key       (start_key),
        .pause_key       (pause_key),
        .lose_sig        (lose_sig),
        .brick_collision (brick_collision),
        .game_state      (game_state),
        .game_reset      (game_reset),
        .lives           (lives),
        .score           (score),
        .bricks_left     (bricks_left),
        .serve_active    (serve_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Holds a key low for low_cyc cycles, then watches a 20-cycle window.
    task automatic press(input bit is_start, input int low_cyc,
                         output int first_rst, output int n_rst, output int n_serve);
        first_rst = -1;
        n_rst     = 0;
        n_serve   = 0;
        if (is_start) start_key = 1'b0;
        else          pause_key = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (game_reset === 1'b1) begin
                n_rst++;
                if (first_rst < 0) first_rst = k;
            end
            if (serve_active === 1'b1) n_serve++;
            if (k == low_cyc) begin
                start_key = 1'b1;
                pause_key = 1'b1;
            end
        end
    endtask

    task automatic wait_state(input string tag, input logic [1:0] exp, input int budget);
        for (int k = 0; k < budget && game_state !== exp; k++) @(negedge clk);
        check(tag, int'(game_state), int'(exp));
    endtask

    task automatic lose_once(input string tag, input int exp_lives);
        lose_sig = 1'b1;
        @(negedge clk);
        check({tag, "_lives"}, int'(lives), exp_lives);
        check({tag, "_rst"}, int'(game_reset), 1);
        check({tag, "_state"}, int'(game_state), 0);
        check({tag, "_serve"}, int'(serve_active), 1);
        lose_sig = 1'b0;
        @(negedge clk);
        check({tag, "_rst_once"}, int'(game_reset), 0);
        wait_state({tag, "_replay"}, 2'b01, 20);
    endtask

    task automatic hit_once(input logic [NB-1:0] mask);
        brick_collision = mask;
        @(negedge clk);
        brick_collision = '0;
        @(negedge clk);
    endtask

    initial begin
        int first_rst, n_rst, n_serve;

        rst_n           = 1'b0;
        start_key       = 1'b1;
        pause_key       = 1'b1;
        lose_sig        = 1'b0;
        brick_collision = '0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(game_state), 0);
        check("rst_greset", int'(game_reset), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_score", int'(score), 0);
        check("rst_bricks", int'(bricks_left), 50);
        check("rst_serve", int'(serve_active), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Debounce: a 3-cycle glitch is rejected, a 10-cycle press is accepted once.
        press(1'b1, 3, first_rst, n_rst, n_serve);
        check("glitch_nrst", n_rst, 0);
        check("glitch_state", int'(game_state), 0);
        press(1'b1, 10, first_rst, n_rst, n_serve);
        check("start_rst_at", first_rst, 7);
        check("start_nrst", n_rst, 1);
        check("start_serve_len", n_serve, 8);
        check("start_play", int'(game_state), 1);

        // Scoring: two bricks held high for 5 cycles count once.
        brick_collision = '0;
        brick_collision[0] = 1'b1;
        brick_collision[7] = 1'b1;
        @(negedge clk);
        check("hit2_score", int'(score), 20);
        check("hit2_bricks", int'(bricks_left), 48);
        repeat (4) @(negedge clk);
        brick_collision = '0;
        @(negedge clk);
        check("hit2_score_once", int'(score), 20);
        check("hit2_bricks_once", int'(bricks_left), 48);

        // Pause: hits and a lose are ignored; the held lose is not counted on resume.
        press(1'b0, 8, first_rst, n_rst, n_serve);
        check("pause_state", int'(game_state), 0);
        check("pause_nrst", n_rst, 0);
        brick_collision[1] = 1'b1;
        brick_collision[2] = 1'b1;
        lose_sig = 1'b1;
        repeat (3) @(negedge clk);
        brick_collision = '0;
        @(negedge clk);
        check("pause_score", int'(score), 20);
        check("pause_bricks", int'(bricks_left), 48);
        check("pause_lives", int'(lives), 3);
        press(1'b0, 8, first_rst, n_rst, n_serve);
        check("resume_state", int'(game_state), 1);
        check("resume_lives", int'(lives), 3);
        lose_sig = 1'b0;
        @(negedge clk);

        lose_once("lose1", 2);
        lose_once("lose2", 1);

        // Win with a coincident lose: win takes priority.
        brick_collision = '1;
        brick_collision[2:0] = '0;
        @(negedge clk);
        brick_collision = '0;
        check("pre_win_score", int'(score), 490);
        check("pre_win_bricks", int'(bricks_left), 1);
        @(negedge clk);
        brick_collision[1] = 1'b1;
        lose_sig = 1'b1;
        @(negedge clk);
        check("win_state", int'(game_state), 2);
        check("win_lives", int'(lives), 1);
        check("win_greset", int'(game_reset), 0);
        check("win_score", int'(score), 500);
        check("win_bricks", int'(bricks_left), 0);
        brick_collision = '0;
        lose_sig = 1'b0;
        repeat (4) @(negedge clk);
        check("win_hold", int'(game_state), 2);
        check("win_hold_rst", int'(game_reset), 0);

        // Restart from WIN, then three losses end the game.
        press(1'b1, 8, first_rst, n_rst, n_serve);
        check("restart_nrst", n_rst, 1);
        check("restart_lives", int'(lives), 3);
        check("restart_score", int'(score), 0);
        check("restart_bricks", int'(bricks_left), 50);
        check("restart_play", int'(game_state), 1);
        lose_once("g2_lose1", 2);
        lose_once("g2_lose2", 1);
        lose_sig = 1'b1;
        @(negedge clk);
        check("over_lives", int'(lives), 0);
        check("over_state", int'(game_state), 3);
        check("over_greset", int'(game_reset), 0);
        lose_sig = 1'b0;
        hit_once(NB'(64'h3));
        check("over_hold", int'(game_state), 3);
        check("over_score", int'(score), 0);

        // Restart from OVER, score 300, lose once, then reset during SERVE.
        press(1'b1, 8, first_rst, n_rst, n_serve);
        check("restart2_nrst", n_rst, 1);
        check("restart2_play", int'(game_state), 1);
        hit_once(NB'(64'h3FFF_FFFF));
        check("g3_score", int'(score), 300);
        check("g3_bricks", int'(bricks_left), 20);
        lose_sig = 1'b1;
        @(negedge clk);
        lose_sig = 1'b0;
        @(negedge clk);
        check("g3_serve", int'(serve_active), 1);
        check("g3_score_hold", int'(score), 300);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_state", int'(game_state), 0);
        check("mid_rst_serve", int'(serve_active), 0);
        check("mid_rst_score", int'(score), 0);
        check("mid_rst_lives", int'(lives), 3);
        check("mid_rst_bricks", int'(bricks_left), 50);
        check("mid_rst_greset", int'(game_reset), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_rst = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (game_reset === 1'b1) n_rst++;
        end
        check("post_rst_nrst", n_rst, 0);
        check("post_rst_state", int'(game_state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
